// File: rtl/halfword_ram.sv
// Wait-stated 16-bit single-port RAM on a simple cyc/stb/ack bus, byte or halfword access.
// Define HWRAM_ERR_EN to flag out-of-range addresses on s_err_o instead of aliasing them.
module halfword_ram #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] s_adr_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic        s_siz_i,
  input  logic        s_signed_i,
  input  logic [15:0] s_dat_i,
  output logic        s_ack_o,
  output logic [15:0] s_dat_o
`ifdef HWRAM_ERR_EN
  ,
  output logic        s_err_o
`endif
);

  localparam int         WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_C  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [3:0]              cnt_r, cnt_s;
  logic [DEPTH_LOG2-1:0]   word_r;
  logic                    lane_r, we_r, siz_r, oor_r;
  logic [15:0]             wdat_r;
  logic                    ack_r, err_r;
  logic [15:0]             dat_r;

  logic                    req_s, commit_s, oor_in_s;
  logic [DEPTH_LOG2-1:0]   t_word_s;
  logic                    t_lane_s, t_we_s, t_siz_s, t_oor_s;
  logic [15:0]             t_dat_s, rd_s;
  logic                    wr_lo_s, wr_hi_s;
  logic [7:0]              hi_byte_s;
  logic                    unused_s;

  logic [7:0] mem_lo [WORDS];
  logic [7:0] mem_hi [WORDS];

`ifdef HWRAM_ERR_EN
  assign oor_in_s = |s_adr_i[63:DEPTH_LOG2+1];
  assign s_err_o  = err_r;
  assign unused_s = s_signed_i;
`else
  assign oor_in_s = 1'b0;
  assign unused_s = ^{s_signed_i, s_adr_i[63:DEPTH_LOG2+1], err_r};
`endif

  assign s_ack_o = ack_r;
  assign s_dat_o = dat_r;

  // Transfer attributes: live inputs when committing straight from IDLE, latched copies otherwise.
  always_comb begin
    t_word_s = word_r;
    t_lane_s = lane_r;
    t_we_s   = we_r;
    t_siz_s  = siz_r;
    t_dat_s  = wdat_r;
    t_oor_s  = oor_r;
    if (state_r == ST_IDLE) begin
      t_word_s = s_adr_i[DEPTH_LOG2:1];
      t_lane_s = s_adr_i[0];
      t_we_s   = s_we_i;
      t_siz_s  = s_siz_i;
      t_dat_s  = s_dat_i;
      t_oor_s  = oor_in_s;
    end else begin
      t_word_s = word_r;
    end
  end

  // Next-state and wait counter; commit marks the edge that enters ACK.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    req_s    = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          req_s = 1'b1;
          cnt_s = WS_C;
          if (WS_C == 4'd0) begin
            state_s  = ST_ACK;
            commit_s = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!s_cyc_i) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r == 4'd1) begin
          state_s  = ST_ACK;
          cnt_s    = 4'd0;
          commit_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_ACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Byte-lane write enables and read-data formatting.
  always_comb begin
    wr_lo_s   = commit_s & t_we_s & ~t_oor_s & ~reset_i & (t_siz_s | ~t_lane_s);
    wr_hi_s   = commit_s & t_we_s & ~t_oor_s & ~reset_i & (t_siz_s | t_lane_s);
    hi_byte_s = t_siz_s ? t_dat_s[15:8] : t_dat_s[7:0];
    if (t_siz_s) begin
      rd_s = {mem_hi[t_word_s], mem_lo[t_word_s]};
    end else if (t_lane_s) begin
      rd_s = {8'h00, mem_hi[t_word_s]};
    end else begin
      rd_s = {8'h00, mem_lo[t_word_s]};
    end
  end

  // FSM state, latched request and registered bus outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      word_r  <= '0;
      lane_r  <= 1'b0;
      we_r    <= 1'b0;
      siz_r   <= 1'b0;
      oor_r   <= 1'b0;
      wdat_r  <= 16'h0000;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_r   <= 16'h0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= commit_s & ~t_oor_s;
      err_r   <= commit_s & t_oor_s;
      if (req_s) begin
        word_r <= t_word_s;
        lane_r <= t_lane_s;
        we_r   <= t_we_s;
        siz_r  <= t_siz_s;
        oor_r  <= t_oor_s;
        wdat_r <= t_dat_s;
      end
      if (commit_s && !t_we_s && !t_oor_s) begin
        dat_r <= rd_s;
      end
    end
  end

  // Storage is split into byte lanes so byte writes need no read-modify-write.
  always_ff @(posedge clk_i) begin
    if (wr_lo_s) begin
      mem_lo[t_word_s] <= t_dat_s[7:0];
    end
    if (wr_hi_s) begin
      mem_hi[t_word_s] <= hi_byte_s;
    end
  end

endmodule
